// File: rtl/cache_pkg.sv
// Shared types and constants for the MEM-stage cache block-fill controller.
package cache_pkg;

  localparam int BLOCK_WORDS   = 8;
  localparam int MEM_LATENCY   = 4;
  localparam int WORD_OFF_BITS = 3;
  localparam int CNT_W         = $clog2(BLOCK_WORDS) + 1;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  typedef logic [CNT_W-1:0]         fill_cnt_t;
  typedef logic [WORD_OFF_BITS-1:0] word_idx_t;

  localparam fill_cnt_t CNT_FULL = fill_cnt_t'(BLOCK_WORDS);
  localparam fill_cnt_t CNT_LAST = fill_cnt_t'(BLOCK_WORDS - 1);

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder/subtractor: 4-bit groups with lookahead
// between groups and ripple inside each group.
module cla_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] sum_o
);

  logic [15:0] b_eff;
  logic [14:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_c;

  always_comb begin
    b_eff    = b_i ^ {16{sub_i}};
    g        = a_i[14:0] & b_eff[14:0];
    p        = a_i ^ b_eff;
    grp_c    = '0;
    grp_c[0] = sub_i;
    for (int k = 0; k < 3; k++) begin
      grp_c[k+1] = g[4*k+3]
                 | (p[4*k+3] & g[4*k+2])
                 | ((&p[4*k+2 +: 2]) & g[4*k+1])
                 | ((&p[4*k+1 +: 3]) & g[4*k])
                 | ((&p[4*k +: 4]) & grp_c[k]);
    end
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    sum_o = p ^ c;
  end

endmodule

// File: rtl/fill_addr_gen.sv
// Request address for one fill word: block base + (word index << 1).
module fill_addr_gen
  import cache_pkg::*;
(
  input  logic [15:0] base_i,
  input  word_idx_t   idx_i,
  output logic [15:0] addr_o
);

  logic [15:0] byte_off;

  assign byte_off = {{(16-WORD_OFF_BITS-1){1'b0}}, idx_i, 1'b0};

  cla_16bit u_cla (
    .a_i   (base_i),
    .b_i   (byte_off),
    .sub_i (1'b0),
    .sum_o (addr_o)
  );

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block-fill controller: issues one read per block word, steers returns
// into the data array, pulses the tag write on the last word.
// Optional build macro CACHE_FILL_CRITICAL_WORD_FIRST_EN: wrap-around fill
// starting at the missed word.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output word_idx_t   fill_word_offset,
  output logic        write_tag_array
);

  fill_state_t state_q, state_d;
  fill_cnt_t   issue_cnt_q, issue_cnt_d;
  fill_cnt_t   recv_cnt_q, recv_cnt_d;
  logic [15:0] base_q, base_d;
  word_idx_t   issue_idx, recv_idx;
  logic [15:0] req_addr;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  word_idx_t start_q, start_d;

  // 3-bit sums wrap at the block boundary by construction.
  assign issue_idx = start_q + issue_cnt_q[WORD_OFF_BITS-1:0];
  assign recv_idx  = start_q + recv_cnt_q[WORD_OFF_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= '0;
    else        start_q <= start_d;
  end
`else
  assign issue_idx = issue_cnt_q[WORD_OFF_BITS-1:0];
  assign recv_idx  = recv_cnt_q[WORD_OFF_BITS-1:0];
`endif

  fill_addr_gen u_addr_gen (
    .base_i (base_q),
    .idx_i  (issue_idx),
    .addr_o (req_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    start_d          = start_q;
`endif
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_offset = '0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d      = miss_address & BLOCK_MASK;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
          start_d     = miss_address[WORD_OFF_BITS:1];
`endif
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < CNT_FULL) begin
          mem_en         = 1'b1;
          memory_address = req_addr;
          issue_cnt_d    = issue_cnt_q + 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word_offset = recv_idx;
          recv_cnt_d       = recv_cnt_q + 1'b1;
          if (recv_cnt_q == CNT_LAST) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed self-checking bench for cache_fill_fsm with a pipelined
// fixed-latency memory model (MEM_LATENCY = 4).
module tb_cache_fill_fsm;

  typedef logic [15:0] tab_t [8];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        spurious_valid;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  fill_word_offset;
  logic        write_tag_array;

  logic [3:0]  vpipe = '0;
  int          total = 0;
  int          bad   = 0;

  tab_t a1236, o1236, afffe, offfe, a4a52, o4a52;

  always #5 clk = ~clk;

  // Memory returns each request exactly four cycles after it was issued.
  always @(posedge clk) vpipe <= {vpipe[2:0], mem_en};
  assign memory_data_valid = vpipe[3] | spurious_valid;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_offset  (fill_word_offset),
    .write_tag_array   (write_tag_array)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"},  16'(fsm_busy), 16'h0);
    check({tag, " mem_en"}, 16'(mem_en), 16'h0);
    check({tag, " addr"},  memory_address, 16'h0);
    check({tag, " wda"},   16'(write_data_array), 16'h0);
    check({tag, " off"},   16'(fill_word_offset), 16'h0);
    check({tag, " tag"},   16'(write_tag_array), 16'h0);
  endtask

  // Called at a negedge. Cycle c counts from the first cycle after the
  // sampling edge; requests in c=1..8, returns in c=5..12, busy c=1..12.
  task automatic run_fill(input string name, input logic [15:0] addr,
                          input tab_t exp_addr, input tab_t exp_off,
                          input bit hold_miss, input int stop_c);
    miss_address  = addr;
    miss_detected = 1'b1;
    @(negedge clk);
    if (!hold_miss) miss_detected = 1'b0;
    for (int c = 1; c <= stop_c; c++) begin
      if (hold_miss && c == 12) miss_detected = 1'b0;
      check($sformatf("%s busy c%0d", name, c), 16'(fsm_busy), 16'(c <= 12));
      check($sformatf("%s mem_en c%0d", name, c), 16'(mem_en), 16'(c <= 8));
      check($sformatf("%s addr c%0d", name, c), memory_address,
            (c <= 8) ? exp_addr[c-1] : 16'h0);
      check($sformatf("%s wda c%0d", name, c), 16'(write_data_array),
            16'(c >= 5 && c <= 12));
      check($sformatf("%s off c%0d", name, c), 16'(fill_word_offset),
            (c >= 5 && c <= 12) ? exp_off[c-5] : 16'h0);
      check($sformatf("%s tag c%0d", name, c), 16'(write_tag_array), 16'(c == 12));
      if (c < stop_c) @(negedge clk);
    end
  endtask

  initial begin
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    a1236 = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
    o1236 = '{16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0, 16'd1, 16'd2};
    afffe = '{16'hFFFE, 16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC};
    offfe = '{16'd7, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    a4a52 = '{16'h4A52, 16'h4A54, 16'h4A56, 16'h4A58, 16'h4A5A, 16'h4A5C, 16'h4A5E, 16'h4A50};
    o4a52 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd0};
`else
    a1236 = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
    o1236 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    afffe = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8, 16'hFFFA, 16'hFFFC, 16'hFFFE};
    offfe = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    a4a52 = '{16'h4A50, 16'h4A52, 16'h4A54, 16'h4A56, 16'h4A58, 16'h4A5A, 16'h4A5C, 16'h4A5E};
    o4a52 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
`endif
    rst_n          = 1'b0;
    miss_detected  = 1'b0;
    miss_address   = 16'h0;
    spurious_valid = 1'b0;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    run_fill("m1236", 16'h1236, a1236, o1236, 1'b0, 14);
    run_fill("mfffe", 16'hFFFE, afffe, offfe, 1'b0, 14);
    run_fill("hold", 16'h1236, a1236, o1236, 1'b1, 14);

    // Returns with no fill in progress must not touch the arrays.
    spurious_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("spur wda %0d", k), 16'(write_data_array), 16'h0);
      check($sformatf("spur tag %0d", k), 16'(write_tag_array), 16'h0);
      check($sformatf("spur busy %0d", k), 16'(fsm_busy), 16'h0);
      @(negedge clk);
    end
    spurious_valid = 1'b0;
    @(negedge clk);
    run_fill("after_spur", 16'h1236, a1236, o1236, 1'b0, 14);

    // Abort after three returned words (accepted at c=5,6,7).
    run_fill("abort", 16'h4A52, a4a52, o4a52, 1'b0, 8);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    check_idle_outputs("in_rst");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("late wda %0d", k), 16'(write_data_array), 16'h0);
      check($sformatf("late tag %0d", k), 16'(write_tag_array), 16'h0);
      check($sformatf("late busy %0d", k), 16'(fsm_busy), 16'h0);
      check($sformatf("late mem_en %0d", k), 16'(mem_en), 16'h0);
    end
    run_fill("refill", 16'h4A52, a4a52, o4a52, 1'b0, 14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Multi-cycle block-fill controller between the MEM-stage cache and main memory. On a cache miss it captures the word-aligned miss address produced by the load/store address path, issues one memory read per word of the enclosing block, steers each returning word into the data array, and writes the tag when the last word lands. While busy it holds the pipeline stall (`fsm_busy`).

## Interface
- BLOCK_WORDS, 8: 16-bit words per cache block (power of two; block = 16 bytes).
- MEM_LATENCY, 4: cycles from request issue to `memory_data_valid`. Memory is pipelined and accepts one request per cycle.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_detected  in  1  level; miss on `miss_address` this cycle
- miss_address  in  16  byte address of the missing access; bit 0 ignored
- memory_data_valid  in  1  one return word valid this cycle
- fsm_busy  out  1  fill in progress; pipeline stalls
- mem_en  out  1  read request valid this cycle
- memory_address  out  16  byte address of the current request
- write_data_array  out  1  write `memory_data` into the data array this cycle
- fill_word_offset  out  3  word index within the block for `write_data_array`
- write_tag_array  out  1  single-cycle tag/valid write pulse

## Operation
- States: IDLE, FILL.
- IDLE: if `miss_detected` is high at a clock edge, register base = `miss_address & 16'hFFF0` and start = `miss_address[3:1]`, clear `issue_cnt` and `recv_cnt`, then go to FILL.
- FILL, issue side: while `issue_cnt < BLOCK_WORDS`, `mem_en=1` and `memory_address = base + 2*idx(issue_cnt)`; increment `issue_cnt` each cycle. Requests are back to back, with no gaps.
- FILL, receive side: on each `memory_data_valid`, `write_data_array=1` and `fill_word_offset = idx(recv_cnt)`; increment `recv_cnt`.
- Last word (`recv_cnt == BLOCK_WORDS-1` with valid): `write_tag_array=1` in that same cycle; next state is IDLE.
- idx(i) = i by default (see Configuration).
- Address arithmetic is 16-bit unsigned with no carry out. The index is 3 bits, so the result never leaves the block.
- `fsm_busy = (state == FILL)`. It is registered-state-derived, with no combinational path from `miss_detected`.

## Timing
- Edge E samples the miss. Cycles E+1 through E+8 issue the requests (words 0..7). Data returns in cycles E+1+MEM_LATENCY through E+8+MEM_LATENCY.
- `fsm_busy` is high for exactly BLOCK_WORDS+MEM_LATENCY cycles (12 at default). It falls the cycle after `write_tag_array`.
- `miss_detected` while in FILL is ignored. The pipeline re-presents the access after the stall drops; a back-to-back miss starts a new fill one cycle after IDLE is entered.
- `memory_data_valid` in IDLE is ignored: no writes, no count change.
- Reset values: state IDLE, all counters 0, `fsm_busy`/`mem_en`/`write_data_array`/`write_tag_array` = 0, `memory_address` = 0, `fill_word_offset` = 0.
- Reset asserted mid-fill aborts immediately: no tag write occurs. Any in-flight returns arriving after reset release land in IDLE and are dropped.

## Configuration
- Macro: `CACHE_FILL_CRITICAL_WORD_FIRST_EN`.
- Defined: idx(i) = (start + i) mod BLOCK_WORDS. The missed word is requested and written first, and the sequence wraps at the block boundary (e.g. start 6 gives 6, 7, 0, 1, ... 5).
- Undefined: idx(i) = i. `start` is not stored, and the fill always begins at word 0.
- Cycle counts and the tag pulse timing are identical in both builds.

## Structure
- Shared package `cache_pkg`:
  - `fill_state_t` (IDLE, FILL)
  - BLOCK_WORDS, WORD_OFF_BITS = 3, BLOCK_MASK = 16'hFFF0
  - counter typedef of width $clog2(BLOCK_WORDS)+1
- One sub-module, `fill_addr_gen`: combinational base + (idx << 1), built on the codebase `cla_16bit` with sub = 0. It is instantiated once, for the issue side; the receive side uses idx only.

## Test plan
- Miss at 0x1236, latency 4: `mem_en` high for 8 cycles with addresses 0x1230, 0x1232 ... 0x123E. Eight `write_data_array` pulses with offsets 0..7, `write_tag_array` coincides with the 8th, and `fsm_busy` is high for 12 cycles.
- Same miss with CRITICAL_WORD_FIRST_EN defined: addresses 0x1236, 0x1238, 0x123A, 0x123C, 0x123E, 0x1230, 0x1232, 0x1234. Offsets 3, 4, 5, 6, 7, 0, 1, 2.
- Miss at 0xFFFE: base 0xFFF0, last address 0xFFFE, with no wrap past 16 bits.
- `miss_detected` held high through the whole fill plus spurious `memory_data_valid` in IDLE: a single fill only, and no array writes outside FILL.
- `rst_n` pulsed low after 3 returned words: all outputs 0 asynchronously, no tag write, and late valids are ignored. A new miss then performs a clean complete fill.
